// File: rtl/aes_shared_io_ctrl.sv
// aes_shared_io_ctrl
//   I/O front-end for the masked round-based AES core. Plaintext and key
//   shares arrive as BUS_W-bit beats on a valid/ready bus and are shifted
//   into N_SHARES x 128-bit load registers. Share 0 comes first, and within
//   a share the most-significant segment comes first. Once both registers
//   are full the block pulses core_go for one cycle and waits for core_done,
//   guarded by a watchdog. It then captures core_out and streams it back out
//   MSB-first on a valid/ready bus, with out_last marking the final beat.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_pt        plaintext share segment (BUS_W)
//   in_key       key share segment, beat-aligned with in_pt (BUS_W)
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid && in_ready
//   core_go      one-cycle start pulse to the core
//   core_pt      loaded shared plaintext, share 0 in the MSBs
//   core_key     loaded shared key, same layout as core_pt
//   core_done    core completion, only honoured while waiting on the core
//   core_out     shared ciphertext, valid with core_done
//   out_data     output beat (BUS_W)
//   out_valid    output beat valid
//   out_ready    sink accepts the beat when out_valid && out_ready
//   out_last     high with the final output beat
//   busy         high in every state except idle
//   timeout_err  sticky watchdog error, cleared by the next accepted first beat
module aes_shared_io_ctrl #(
  parameter int unsigned BUS_W    = 16,
  parameter int unsigned N_SHARES = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_W-1:0]          in_pt,
  input  logic [BUS_W-1:0]          in_key,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      core_go,
  output logic [N_SHARES*128-1:0]   core_pt,
  output logic [N_SHARES*128-1:0]   core_key,
  input  logic                      core_done,
  input  logic [N_SHARES*128-1:0]   core_out,
  output logic [BUS_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned BLK_W = N_SHARES * 128;
  localparam int unsigned BEATS = BLK_W / BUS_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BUSY,
    S_UNLOAD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WD_W-1:0]    wd_q,    wd_d;
  logic [BLK_W-1:0]   pt_q,    pt_d;
  logic [BLK_W-1:0]   key_q,   key_d;
  logic [BLK_W-1:0]   out_q,   out_d;
  logic               err_q,   err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    pt_d    = pt_q;
    key_d   = key_q;
    out_d   = out_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pt_d    = {pt_q[BLK_W-BUS_W-1:0], in_pt};
          key_d   = {key_q[BLK_W-BUS_W-1:0], in_key};
          cnt_d   = CNT_W'(1);
          err_d   = 1'b0;
          state_d = (BEATS == 1) ? S_START : S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          pt_d  = {pt_q[BLK_W-BUS_W-1:0], in_pt};
          key_d = {key_q[BLK_W-BUS_W-1:0], in_key};
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_START: begin
        wd_d    = '0;
        state_d = S_BUSY;
      end

      S_BUSY: begin
        // A done arriving on the watchdog's final cycle takes priority.
        if (core_done) begin
          out_d   = core_out;
          cnt_d   = '0;
          state_d = S_UNLOAD;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_UNLOAD: begin
        if (out_ready) begin
          out_d = {out_q[BLK_W-BUS_W-1:0], {BUS_W{1'b0}}};
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state only; in_ready is additionally held
  // low while reset is asserted so every output reads zero during reset.
  assign in_ready    = reset && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign core_go     = (state_q == S_START);
  assign out_valid   = (state_q == S_UNLOAD);
  assign out_last    = (state_q == S_UNLOAD) && (cnt_q == LAST_BEAT);
  assign busy        = (state_q != S_IDLE);
  assign out_data    = out_q[BLK_W-1 -: BUS_W];
  assign core_pt     = pt_q;
  assign core_key    = key_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_aes_shared_io_ctrl.sv
// tb_aes_shared_io_ctrl
//   Two instances share one stimulus/monitor path selected by 'sel':
//   A = BUS_W 16, 2 shares, TIMEOUT 1024; B = BUS_W 32, 3 shares, TIMEOUT 8.
//   The reference model describes beats positionally: beat i of n fills bit
//   range [(n-1-i)*BUS_W +: BUS_W] of the block, and output beat j is taken
//   from the same position of the core result.
module tb_aes_shared_io_ctrl;

  localparam int unsigned B_TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         sel;
  logic [31:0]  pt_drv, key_drv;
  logic         in_valid, out_ready, core_done;
  logic [383:0] core_out_drv;

  logic         a_in_ready, a_go, a_out_valid, a_out_last, a_busy, a_err;
  logic [255:0] a_pt, a_key;
  logic [15:0]  a_out_data;
  logic         b_in_ready, b_go, b_out_valid, b_out_last, b_busy, b_err;
  logic [383:0] b_pt, b_key;
  logic [31:0]  b_out_data;

  aes_shared_io_ctrl #(.BUS_W(16), .N_SHARES(2), .TIMEOUT(1024)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .in_pt      (pt_drv[15:0]),
    .in_key     (key_drv[15:0]),
    .in_valid   (in_valid & ~sel),
    .in_ready   (a_in_ready),
    .core_go    (a_go),
    .core_pt    (a_pt),
    .core_key   (a_key),
    .core_done  (core_done & ~sel),
    .core_out   (core_out_drv[255:0]),
    .out_data   (a_out_data),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready & ~sel),
    .out_last   (a_out_last),
    .busy       (a_busy),
    .timeout_err(a_err)
  );

  aes_shared_io_ctrl #(.BUS_W(32), .N_SHARES(3), .TIMEOUT(B_TO)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .in_pt      (pt_drv),
    .in_key     (key_drv),
    .in_valid   (in_valid & sel),
    .in_ready   (b_in_ready),
    .core_go    (b_go),
    .core_pt    (b_pt),
    .core_key   (b_key),
    .core_done  (core_done & sel),
    .core_out   (core_out_drv),
    .out_data   (b_out_data),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready & sel),
    .out_last   (b_out_last),
    .busy       (b_busy),
    .timeout_err(b_err)
  );

  logic         m_in_ready, m_go, m_out_valid, m_out_last, m_busy, m_err;
  logic [383:0] m_pt, m_key;
  logic [31:0]  m_out_data;

  always_comb begin
    if (sel) begin
      m_in_ready = b_in_ready; m_go = b_go; m_out_valid = b_out_valid;
      m_out_last = b_out_last; m_busy = b_busy; m_err = b_err;
      m_pt = b_pt; m_key = b_key; m_out_data = b_out_data;
    end else begin
      m_in_ready = a_in_ready; m_go = a_go; m_out_valid = a_out_valid;
      m_out_last = a_out_last; m_busy = a_busy; m_err = a_err;
      m_pt = {128'b0, a_pt}; m_key = {128'b0, a_key}; m_out_data = {16'b0, a_out_data};
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]  pt_q[$];
  logic [31:0]  key_q[$];
  logic [383:0] cout;

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_bw();
    return sel ? 32 : 16;
  endfunction

  function automatic int cur_ns();
    return sel ? 3 : 2;
  endfunction

  function automatic int cur_beats();
    return cur_ns() * 128 / cur_bw();
  endfunction

  function automatic logic [31:0] cur_mask();
    return sel ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  // Beat i lands at segment position (beats-1-i) counted from the LSB.
  function automatic logic [383:0] pack_beats(input logic [31:0] bq[$]);
    logic [383:0] v;
    int bw, n;
    bw = cur_bw();
    n  = cur_beats();
    v  = '0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < bw; b++)
        v[(n-1-i)*bw + b] = bq[i][b];
    return v;
  endfunction

  function automatic logic [31:0] out_beat(input logic [383:0] blk, input int j);
    logic [31:0] r;
    int bw, total;
    bw    = cur_bw();
    total = cur_ns() * 128;
    r     = '0;
    for (int b = 0; b < bw; b++)
      r[b] = blk[total - (j+1)*bw + b];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: counting pattern 1..BEATS with key = ~pt; mode 1: random.
  task automatic gen_data(input int mode);
    logic [31:0] p;
    pt_q.delete();
    key_q.delete();
    for (int i = 0; i < cur_beats(); i++) begin
      p = (mode == 0) ? 32'(i + 1) : ($urandom & cur_mask());
      pt_q.push_back(p);
      key_q.push_back((mode == 0) ? (~p & cur_mask()) : ($urandom & cur_mask()));
    end
    for (int w = 0; w < 12; w++) cout[w*32 +: 32] = $urandom;
    if (!sel) cout[383:256] = '0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check("rst_in_ready", m_in_ready, 0);
    check("rst_go", m_go, 0);
    check("rst_busy", m_busy, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_last", m_out_last, 0);
    check("rst_out_data", m_out_data, 0);
    check("rst_core_pt", m_pt, 0);
    check("rst_core_key", m_key, 0);
    check("rst_timeout_err", m_err, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    core_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rel_in_ready", m_in_ready, 1);
    check("rel_busy", m_busy, 0);
  endtask

  task automatic load(input bit gaps, input int abort_at, output bit aborted, output int cycles);
    int i;
    i = 0;
    cycles = 0;
    aborted = 1'b0;
    while (i < cur_beats() && cycles < 4000) begin
      check("load_in_ready", m_in_ready, 1);
      check("load_go_low", m_go, 0);
      if (i == abort_at) begin
        in_valid = 1'b1;
        pt_drv   = pt_q[i];
        key_drv  = key_q[i];
        do_reset();
        aborted = 1'b1;
        return;
      end
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pt_drv   = in_valid ? pt_q[i]  : $urandom;
      key_drv  = in_valid ? key_q[i] : $urandom;
      step();
      cycles++;
      if (in_valid) begin
        if (i == 0) check("first_beat_clears_err", m_err, 0);
        i++;
      end
    end
    in_valid = 1'b0;
    check("load_all_beats", i, cur_beats());
    check("start_go", m_go, 1);
    check("start_in_ready", m_in_ready, 0);
    check("start_busy", m_busy, 1);
    check("core_pt", m_pt, pack_beats(pt_q));
    check("core_key", m_key, pack_beats(key_q));
  endtask

  // Entered in the core_go cycle; 'delay' cycles later done is driven.
  task automatic run_core(input int delay, input bit expect_timeout);
    logic [383:0] ept, ekey;
    int last;
    ept  = pack_beats(pt_q);
    ekey = pack_beats(key_q);
    last = expect_timeout ? B_TO : delay;
    for (int k = 1; k <= last; k++) begin
      step();
      check("busy_busy", m_busy, 1);
      check("busy_go_low", m_go, 0);
      check("busy_in_ready", m_in_ready, 0);
      check("busy_out_valid", m_out_valid, 0);
      check("busy_err_low", m_err, 0);
      check("busy_pt_stable", m_pt, ept);
      check("busy_key_stable", m_key, ekey);
    end
    if (expect_timeout) begin
      step();
      check("to_err_set", m_err, 1);
      check("to_busy", m_busy, 0);
      check("to_in_ready", m_in_ready, 1);
      check("to_out_valid", m_out_valid, 0);
    end else begin
      core_done    = 1'b1;
      core_out_drv = cout;
      step();
      core_done = 1'b0;
      for (int w = 0; w < 12; w++) core_out_drv[w*32 +: 32] = $urandom;
      check("done_err_low", m_err, 0);
    end
  endtask

  task automatic unload(input bit stalls, input int abort_at, output bit aborted);
    int j, cyc;
    j = 0;
    cyc = 0;
    aborted = 1'b0;
    while (j < cur_beats() && cyc < 4000) begin
      check("ul_out_valid", m_out_valid, 1);
      check("ul_out_data", m_out_data, out_beat(cout, j));
      check("ul_out_last", m_out_last, (j == cur_beats() - 1) ? 1 : 0);
      check("ul_busy", m_busy, 1);
      check("ul_in_ready", m_in_ready, 0);
      if (j == abort_at) begin
        do_reset();
        aborted = 1'b1;
        return;
      end
      out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
      cyc++;
      if (out_ready) j++;
    end
    out_ready = 1'b0;
    check("ul_all_beats", j, cur_beats());
    if (!stalls) check("ul_length", cyc, cur_beats());
    check("post_out_valid", m_out_valid, 0);
    check("post_out_last", m_out_last, 0);
    check("post_busy", m_busy, 0);
    check("post_in_ready", m_in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time budget");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ab;
    int cyc;
    logic [383:0] lit_pt1;

    reset        = 1'b0;
    sel          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    core_done    = 1'b0;
    pt_drv       = '0;
    key_drv      = '0;
    core_out_drv = '0;

    #3;
    check("rst0_in_ready", m_in_ready, 0);
    check("rst0_busy", m_busy, 0);
    check("rst0_out_valid", m_out_valid, 0);
    check("rst0_core_pt", m_pt, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("idle_in_ready", m_in_ready, 1);
    check("idle_busy", m_busy, 0);
    check("idle_go", m_go, 0);
    check("idle_err", m_err, 0);
    check("idle_out_data", m_out_data, 0);

    // core_done while idle must be ignored
    core_done    = 1'b1;
    core_out_drv = {12{32'hA5A5_5A5A}};
    step();
    core_done = 1'b0;
    step();
    check("stray_done_busy", m_busy, 0);
    check("stray_done_out_valid", m_out_valid, 0);
    check("stray_done_out_data", m_out_data, 0);

    // Scenarios 1 and 2: counting pattern, done 11 cycles after go
    gen_data(0);
    cout = {128'b0, {2{128'h00112233445566778899AABBCCDDEEFF}}};
    load(1'b0, -1, ab, cyc);
    check("go_latency", cyc, 16);
    lit_pt1 = {128'b0, 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010};
    check("s1_core_pt_literal", m_pt, lit_pt1);
    run_core(11, 1'b0);
    check("s2_first_out", m_out_data, 32'h0000_0011);
    unload(1'b0, -1, ab);

    // Scenario 3: same data with input gaps and output stalls, then random
    load(1'b1, -1, ab, cyc);
    run_core(5, 1'b0);
    unload(1'b1, -1, ab);
    for (int t = 0; t < 2; t++) begin
      gen_data(1);
      load(1'b1, -1, ab, cyc);
      run_core(int'($urandom_range(1, 20)), 1'b0);
      unload(1'b1, -1, ab);
    end

    // Scenarios 4 and 5 on instance B (32-bit bus, 3 shares, TIMEOUT 8)
    sel = 1'b1;
    step();
    gen_data(1);
    load(1'b0, -1, ab, cyc);
    check("b_go_latency", cyc, 12);
    run_core(0, 1'b1);
    step();
    step();
    check("to_err_sticky", m_err, 1);
    check("to_idle_in_ready", m_in_ready, 1);
    gen_data(1);
    load(1'b0, -1, ab, cyc);
    run_core(B_TO, 1'b0);
    unload(1'b0, -1, ab);
    gen_data(1);
    load(1'b1, -1, ab, cyc);
    run_core(3, 1'b0);
    unload(1'b1, -1, ab);

    // Timeout flag is cleared by reset
    gen_data(1);
    load(1'b0, -1, ab, cyc);
    run_core(0, 1'b1);
    do_reset();

    // Scenario 6: reset during load beat 5 and during unload beat 3
    sel = 1'b0;
    step();
    gen_data(1);
    load(1'b0, 4, ab, cyc);
    check("abort_load_taken", ab, 1);
    gen_data(1);
    load(1'b0, -1, ab, cyc);
    run_core(2, 1'b0);
    unload(1'b0, -1, ab);
    gen_data(1);
    load(1'b0, -1, ab, cyc);
    run_core(4, 1'b0);
    unload(1'b0, 2, ab);
    check("abort_unload_taken", ab, 1);
    gen_data(1);
    load(1'b1, -1, ab, cyc);
    run_core(7, 1'b0);
    unload(1'b1, -1, ab);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_shared_io_ctrl.md
Name: aes_shared_io_ctrl

Overview:
- Parametrised I/O front-end for the masked round-based AES core.
- Deserialises shared plaintext and key beats from a narrow valid/ready bus into full-width N_SHARES x 128-bit registers.
- Issues a one-cycle start to the core, waits for its done with a watchdog, captures the shared ciphertext, and serialises it out on a valid/ready bus with a last marker.
- Generalises the fixed 16-bit, 2-share top-level load path in bus width and share count, and adds handshaking, framing and timeout detection.

Parameters:
- BUS_W, 16: bits per beat on each input lane and on the output lane; must divide 128 (8, 16, 32, 64, 128).
- N_SHARES, 2: number of Boolean shares per 128-bit block; range 2..4.
- TIMEOUT, 1024: maximum cycles from core_go to core_done before the error is flagged; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_pt  in  BUS_W  plaintext share segment.
- in_key  in  BUS_W  key share segment, beat-aligned with in_pt.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- core_go  out  1  one-cycle start pulse to the core.
- core_pt  out  N_SHARES*128  loaded shared plaintext; share 0 in the MSBs.
- core_key  out  N_SHARES*128  loaded shared key; same layout as core_pt.
- core_done  in  1  core completion; sampled only in BUSY.
- core_out  in  N_SHARES*128  shared ciphertext; valid when core_done=1.
- out_data  out  BUS_W  output beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat when out_valid && out_ready.
- out_last  out  1  high with the final output beat.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky error flag; cleared on the next accepted first input beat.

Behaviour:
- BEATS = N_SHARES*128/BUS_W. beat_cnt is ceil(log2(BEATS)) bits wide (1 bit minimum).
- Reset (async assert, sync release): state=IDLE; beat_cnt=0; core_pt, core_key and the output shift register = 0. All outputs = 0, except in_ready = 1 once reset is released.
- Beat ordering:
  - Input and output both run share 0 first.
  - Within a share, the most-significant BUS_W segment goes first.
  - Implementation: load register shifts left by BUS_W, new beat into the LSBs.
- IDLE:
  - in_ready=1.
  - An accepted beat stores data, sets beat_cnt=1 and clears timeout_err.
  - Next state is LOAD, or START if BEATS=1.
- LOAD:
  - in_ready=1.
  - Each accepted beat shifts both registers and increments beat_cnt.
  - The beat taken with beat_cnt=BEATS-1 moves the state to START.
  - in_valid low means stall: no change.
- START:
  - in_ready=0; core_go=1 for exactly this cycle.
  - Clear the watchdog counter; next state is BUSY.
- BUSY:
  - in_ready=0; core_pt and core_key held stable.
  - If core_done=1: capture core_out into the output shift register, set beat_cnt=0, go to UNLOAD.
  - Otherwise increment the watchdog. If it reaches TIMEOUT-1 without core_done: set timeout_err=1, go to IDLE; output register not loaded.
  - If core_done arrives in the same cycle the watchdog reaches TIMEOUT-1, done wins and no error is flagged.
- UNLOAD:
  - out_valid=1; out_data = top BUS_W bits of the shift register.
  - out_last=1 when beat_cnt=BEATS-1.
  - On handshake: shift left by BUS_W and increment beat_cnt.
  - The last handshake goes to IDLE with out_valid=0 on the following cycle.
  - out_data is held stable while out_valid && !out_ready.
- Registered handshake outputs (core_go, out_valid, out_last, busy) are decoded from the state only; no combinational path from in_valid to in_ready.
- Zero-bubble latency with in_valid and out_ready held high:
  - first input beat to core_go = BEATS cycles;
  - core_done to first out_valid = 1 cycle;
  - UNLOAD lasts BEATS cycles.
- core_done outside BUSY is ignored.
- Reset asserted mid-operation aborts immediately to the reset state; partial data is discarded and timeout_err is cleared.

Test Plan:
1. Defaults. Stream 16 beats: 0x0001..0x0008 (share 0 of pt), 0x0009..0x0010 (share 1), key = ~pt per beat. Required: core_go pulses 16 cycles after the first beat; core_pt = 0x0001..0010 concatenated.
2. Core model asserts done 11 cycles after go with core_out = 256'h00112233..EEFF repeated. Required: out_data sequence 0x0011, 0x2233, ... across 16 beats; out_last only on beat 16; busy drops the cycle after it.
3. Random in_valid gaps and out_ready stalls. Required: data is identical to scenario 2; out_data held during stalls; no beat lost or duplicated.
4. TIMEOUT=8, core never asserts done. Required: timeout_err=1 eight cycles after entering BUSY; state IDLE; in_ready=1. The next accepted beat clears timeout_err.
5. BUS_W=32, N_SHARES=3. Required: 12 input beats, 12 output beats; share order and MSB-first ordering preserved.
6. Assert reset low during beat 5 of LOAD and again during UNLOAD beat 3. Required: all outputs return to reset values asynchronously; the next full transaction completes correctly.
